// File: rtl/fft_peak_finder.sv
// fft_peak_finder
//   Scans the positive-frequency half of a completed FFT held in an external
//   RAM and reports the bin with the largest power (re^2 + im^2).
//   A scan is started by a rising edge of fft_ok seen while idle. Bins
//   BIN_FIRST..BIN_LAST are read one per cycle. The result is published
//   together with a one-cycle done pulse.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous active-high reset
//   fft_ok     : completion flag from the upstream FFT stage (edge triggered)
//   ram_rd     : read enable to the FFT data RAM
//   ram_addr   : read address to the FFT data RAM (held when not reading)
//   ram_rdata  : {re, im}, signed, valid the cycle after ram_rd
//   busy       : high while a scan is in progress
//   done       : one-cycle pulse when peak_idx / peak_mag are updated
//   peak_idx   : bin index of the largest magnitude
//   peak_mag   : re^2 + im^2 of that bin, unsigned
module fft_peak_finder #(
  parameter int AW        = 10,
  parameter int DW        = 16,
  parameter int BIN_FIRST = 1,
  parameter int BIN_LAST  = 511
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fft_ok,
  output logic            ram_rd,
  output logic [AW-1:0]   ram_addr,
  input  logic [2*DW-1:0] ram_rdata,
  output logic            busy,
  output logic            done,
  output logic [AW-1:0]   peak_idx,
  output logic [2*DW:0]   peak_mag
);

  localparam int MW = 2 * DW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic          fft_ok_q;
  logic          trig;
  logic          last_addr;
  logic          scan_start;
  logic          load_peak;

  logic          ram_rd_q, ram_rd_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;

  // Stage 1: RAM data is on ram_rdata, tagged with the address it came from.
  logic          rd_vld_q;
  logic [AW-1:0] idx1_q;
  // Stage 2: registered power of that bin.
  logic          mag_vld_q;
  logic [AW-1:0] idx2_q;
  logic [MW-1:0] mag_q, mag_d;

  logic [MW-1:0] best_mag_q, best_mag_d;
  logic [AW-1:0] best_idx_q, best_idx_d;

  logic [AW-1:0] peak_idx_q;
  logic [MW-1:0] peak_mag_q;

  // Squares of the two components; gi=0 is im, gi=1 is re. Each component is
  // sign-extended to 2*DW so that (-2^(DW-1))^2 is exact.
  logic [2*DW-1:0] comp_sq [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_sq
    logic signed [2*DW-1:0] comp_ext;
    assign comp_ext    = {{DW{ram_rdata[gi*DW + DW - 1]}}, ram_rdata[gi*DW +: DW]};
    assign comp_sq[gi] = comp_ext * comp_ext;
  end

  assign mag_d = {1'b0, comp_sq[0]} + {1'b0, comp_sq[1]};

  // Edge detect only; a level held high does not retrigger.
  assign trig      = fft_ok & ~fft_ok_q;
  assign last_addr = (ram_addr_q == AW'(BIN_LAST));

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (trig) state_d = S_READ;
      S_READ:  if (last_addr) state_d = S_DRAIN;
      // Once the last RAM word has left stage 1, the final compare happens
      // on this edge, so the result is ready exactly when DONE starts.
      S_DRAIN: if (!rd_vld_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs and datapath controls
  // ---------------------------------------------------------------------
  always_comb begin
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    scan_start = (state_q == S_IDLE) && trig;
    load_peak  = (state_q == S_DRAIN) && !rd_vld_q;
    ram_rd_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    if (scan_start) begin
      ram_rd_d   = 1'b1;
      ram_addr_d = AW'(BIN_FIRST);
    end else if ((state_q == S_READ) && !last_addr) begin
      ram_rd_d   = 1'b1;
      ram_addr_d = ram_addr_q + AW'(1);
    end
  end

  // Best-so-far: strict greater-than keeps the lowest index on ties.
  always_comb begin
    best_mag_d = best_mag_q;
    best_idx_d = best_idx_q;
    if (scan_start) begin
      best_mag_d = '0;
      best_idx_d = AW'(BIN_FIRST);
    end else if (mag_vld_q && (mag_q > best_mag_q)) begin
      best_mag_d = mag_q;
      best_idx_d = idx2_q;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: state register and pipeline registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fft_ok_q   <= 1'b0;
      ram_rd_q   <= 1'b0;
      ram_addr_q <= '0;
      rd_vld_q   <= 1'b0;
      idx1_q     <= '0;
      mag_vld_q  <= 1'b0;
      idx2_q     <= '0;
      mag_q      <= '0;
      best_mag_q <= '0;
      best_idx_q <= '0;
      peak_idx_q <= '0;
      peak_mag_q <= '0;
    end else begin
      state_q    <= state_d;
      fft_ok_q   <= fft_ok;
      ram_rd_q   <= ram_rd_d;
      ram_addr_q <= ram_addr_d;
      rd_vld_q   <= ram_rd_q;
      idx1_q     <= ram_addr_q;
      mag_vld_q  <= rd_vld_q;
      idx2_q     <= idx1_q;
      if (rd_vld_q) begin
        mag_q <= mag_d;
      end
      best_mag_q <= best_mag_d;
      best_idx_q <= best_idx_d;
      // Load from the next-state value so the final compare is included.
      if (load_peak) begin
        peak_idx_q <= best_idx_d;
        peak_mag_q <= best_mag_d;
      end
    end
  end

  assign ram_rd   = ram_rd_q;
  assign ram_addr = ram_addr_q;
  assign peak_idx = peak_idx_q;
  assign peak_mag = peak_mag_q;

endmodule
